sr_cmd_gen: RTL and testbench

SR_CMD_GEN -- requirements
Module: sr_cmd_gen

---
 rtl/sr_pkg.sv | 27 ++
 rtl/debounce_cell.sv | 55 +++++
 rtl/sr_cmd_gen.sv | 83 ++++++++
 tb/tb_sr_cmd_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the SR command generator: parameter defaults and
// the command encoding used by the set/clear arbiter.
package sr_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF           = 8;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        SET  = 2'd1,
        CLR  = 2'd2
    } sr_cmd_e;

    // Simultaneous rising edges cancel each other; the conflict flag is
    // reported separately so the downstream flop never sees s and r together.
    function automatic sr_cmd_e sr_arbitrate(input logic rise_set, input logic rise_clr);
        sr_cmd_e cmd;
        cmd = NONE;
        if (rise_set && !rise_clr) begin
            cmd = SET;
        end else if (rise_clr && !rise_set) begin
            cmd = CLR;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// Two-flop synchronizer followed by a consecutive-sample debounce counter.
// The stable level flips on the DEBOUNCE_CYCLES-th mismatching synchronized sample.
module debounce_cell
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic lvl
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             lvl_q,   lvl_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        lvl_d   = lvl_q;
        cnt_d   = '0;
        // The counter only ever reaches CNT_LAST; the next mismatch toggles
        // the level and clears it, so it can never wrap.
        if (sync2_q != lvl_q) begin
            if (cnt_q >= CNT_LAST) begin
                lvl_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lvl = lvl_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns two bouncy raw request lines into single-cycle s/r pulses for an SR
// flop, with a conflict pulse when both qualify on the same edge.
module sr_cmd_gen
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic set_req,
    input  logic clr_req,
    output logic s,
    output logic r,
    output logic conflict,
    output logic set_lvl,
    output logic clr_lvl
);

    logic    set_lvl_w, clr_lvl_w;
    logic    set_prev_q, set_prev_d;
    logic    clr_prev_q, clr_prev_d;
    logic    s_q, s_d;
    logic    r_q, r_d;
    logic    conflict_q, conflict_d;
    logic    rise_set, rise_clr;
    sr_cmd_e cmd;

    debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_set_cell (
        .clk   (clk),
        .reset (reset),
        .raw_in(set_req),
        .lvl   (set_lvl_w)
    );

    debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_clr_cell (
        .clk   (clk),
        .reset (reset),
        .raw_in(clr_req),
        .lvl   (clr_lvl_w)
    );

    // Only rising edges of the debounced levels generate commands.
    always_comb begin
        set_prev_d = set_lvl_w;
        clr_prev_d = clr_lvl_w;
        rise_set   = set_lvl_w & ~set_prev_q;
        rise_clr   = clr_lvl_w & ~clr_prev_q;
        cmd        = sr_arbitrate(rise_set, rise_clr);
        s_d        = (cmd == SET);
        r_d        = (cmd == CLR);
        conflict_d = rise_set & rise_clr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            set_prev_q <= 1'b0;
            clr_prev_q <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            set_prev_q <= set_prev_d;
            clr_prev_q <= clr_prev_d;
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign conflict = conflict_q;
    assign set_lvl  = set_lvl_w;
    assign clr_lvl  = clr_lvl_w;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench for sr_cmd_gen at DEBOUNCE_CYCLES=4: expected pulses
// are queued as {kind, cycle} when stimulus is driven and matched on output.
module tb_sr_cmd_gen;

    localparam int W = 32;
    localparam logic [1:0] K_SET  = 2'd1;
    localparam logic [1:0] K_CLR  = 2'd2;
    localparam logic [1:0] K_CONF = 2'd3;

    logic clk;
    logic reset;
    logic set_req;
    logic clr_req;
    logic s, r, conflict, set_lvl, clr_lvl;

    logic [W-1:0] exp_q[$];
    int checks;
    int errors;
    int cyc;

    sr_cmd_gen dut (
        .clk     (clk),
        .reset   (reset),
        .set_req (set_req),
        .clr_req (clr_req),
        .s       (s),
        .r       (r),
        .conflict(conflict),
        .set_lvl (set_lvl),
        .clr_lvl (clr_lvl)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ev(input logic [1:0] kind, input int c);
        return {kind, 30'(c)};
    endfunction

    // scoreboard: every observed pulse must match the head of the queue
    always @(negedge clk) begin
        check_eq("s_and_r", {31'd0, s & r}, '0);
        assert (!(s && r));
        if (s) begin
            if (exp_q.size() == 0) check_eq("unexpected_s", ev(K_SET, cyc), '0);
            else check_eq("pulse_s", ev(K_SET, cyc), exp_q.pop_front());
        end
        if (r) begin
            if (exp_q.size() == 0) check_eq("unexpected_r", ev(K_CLR, cyc), '0);
            else check_eq("pulse_r", ev(K_CLR, cyc), exp_q.pop_front());
        end
        if (conflict) begin
            if (exp_q.size() == 0) check_eq("unexpected_conflict", ev(K_CONF, cyc), '0);
            else check_eq("pulse_conflict", ev(K_CONF, cyc), exp_q.pop_front());
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outs_zero(input string tag);
        check_eq({tag, "_outs"}, {27'd0, s, r, conflict, set_lvl, clr_lvl}, '0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        set_req = 1'b0;
        clr_req = 1'b0;
        #1;
        check_outs_zero("in_reset");
        step(2);
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        step(15);
        check_eq({tag, "_queue_empty"}, 32'(exp_q.size()), '0);
        exp_q.delete();
    endtask

    int k;
    int m;
    int dur;
    int total;

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        set_req = 1'b0;
        clr_req = 1'b0;
        #3;
        check_outs_zero("power_on");

        // single set press, long hold, then release: one s pulse only
        do_reset();
        step(3);
        k = cyc;
        set_req = 1'b1;
        exp_q.push_back(ev(K_SET, k + 7));
        step(5);
        check_eq("set_lvl_before", {31'd0, set_lvl}, '0);
        step(1);
        check_eq("set_lvl_after", {31'd0, set_lvl}, 32'd1);
        step(34);
        set_req = 1'b0;
        drain("hold");
        check_eq("set_lvl_fell", {31'd0, set_lvl}, '0);

        // short clr glitch: no level change, no pulse
        do_reset();
        step(3);
        clr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_eq("glitch_clr_lvl", {31'd0, clr_lvl}, '0);
        end
        clr_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            check_eq("glitch_clr_lvl_post", {31'd0, clr_lvl}, '0);
        end
        drain("glitch");

        // clr alone
        do_reset();
        step(2);
        k = cyc;
        clr_req = 1'b1;
        exp_q.push_back(ev(K_CLR, k + 7));
        step(20);
        clr_req = 1'b0;
        drain("clr_alone");

        // simultaneous rise: conflict only
        do_reset();
        step(4);
        k = cyc;
        set_req = 1'b1;
        clr_req = 1'b1;
        exp_q.push_back(ev(K_CONF, k + 7));
        step(20);
        set_req = 1'b0;
        clr_req = 1'b0;
        drain("conflict");

        // adjacent rises on different channels: both pulses
        do_reset();
        step(3);
        k = cyc;
        set_req = 1'b1;
        exp_q.push_back(ev(K_SET, k + 7));
        step(1);
        clr_req = 1'b1;
        exp_q.push_back(ev(K_CLR, k + 8));
        step(20);
        set_req = 1'b0;
        clr_req = 1'b0;
        drain("adjacent");

        // reset mid-debounce, input held across release
        do_reset();
        step(3);
        set_req = 1'b1;
        step(4);
        reset = 1'b1;
        #1;
        check_outs_zero("mid_debounce_rst");
        step(2);
        reset = 1'b0;
        m = cyc;
        exp_q.push_back(ev(K_SET, m + 7));
        step(20);
        set_req = 1'b0;
        drain("rst_release");

        // reset mid-pulse discards the event
        do_reset();
        step(3);
        set_req = 1'b1;
        step(7);
        check_eq("s_before_rst", {31'd0, s}, 32'd1);
        reset = 1'b1;
        #1;
        check_outs_zero("mid_pulse_rst");
        set_req = 1'b0;
        step(2);
        reset = 1'b0;
        drain("mid_pulse");

        // random bounce then steady high: exactly one s pulse
        do_reset();
        step(2);
        total = 0;
        while (total < 50) begin
            dur = $urandom_range(1, 3);
            set_req = ~set_req;
            step(dur);
            total += dur;
            check_eq("bounce_set_lvl", {31'd0, set_lvl}, '0);
        end
        set_req = 1'b0;
        step(1);
        k = cyc;
        set_req = 1'b1;
        exp_q.push_back(ev(K_SET, k + 7));
        step(30);
        set_req = 1'b0;
        drain("bounce");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
